// File: rtl/lock_controller.sv
// ---------------------------------------------------------------------------
// lock_controller
//
// Purpose:
//   Sits downstream of the code detector. It forwards the user Start request
//   into the detector, times the window after Start in which the detector's
//   unlock flag U is sampled, drives the lock actuator for a fixed hold time
//   on success, and counts consecutive failures. When the failure count
//   reaches MAX_FAILS, it raises Alarm and blocks Start for a lockout period.
//
// Ports:
//   Clk         in   system clock, rising edge
//   Rst         in   synchronous active-high reset
//   Start_In    in   user start request
//   U           in   unlock flag from the code detector
//   Start_Out   out  Start forwarded to the detector (combinational)
//   Unlock      out  lock actuator drive (registered)
//   Alarm       out  lockout indicator (registered)
//   Fail_Count  out  consecutive-failure count (registered)
// ---------------------------------------------------------------------------
module lock_controller #(
  parameter int CODE_LEN       = 4,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 200,
  parameter int MAX_FAILS      = 3,
  parameter int CNT_W          = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start_In,
  input  logic       U,
  output logic       Start_Out,
  output logic       Unlock,
  output logic       Alarm,
  output logic [1:0] Fail_Count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CODE_LEN_C    = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0] UNLOCK_LAST_C = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST_C   = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE_C   = CNT_W'(1);
  localparam logic [2:0]       MAX_FAILS_W_C = 3'(MAX_FAILS);
  localparam logic [1:0]       MAX_FAILS_C   = 2'(MAX_FAILS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             unlock_q, unlock_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       fail_q, fail_d;

  // One bit wider so the "next failure reaches the limit" test cannot wrap.
  logic [2:0]       fail_inc;

  assign fail_inc = {1'b0, fail_q} + 3'd1;

  // Forwarding is cut while the lock is open or locked out, and during reset.
  assign Start_Out = Start_In && ((state_q == IDLE) || (state_q == WAIT)) && !Rst;

  assign Unlock     = unlock_q;
  assign Alarm      = alarm_q;
  assign Fail_Count = fail_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      fail_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    unlock_d = unlock_q;
    alarm_d  = alarm_q;
    fail_d   = fail_q;

    unique case (state_q)
      IDLE: begin
        // U is deliberately ignored here.
        if (Start_In) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end

      WAIT: begin
        if (Start_In) begin
          // A fresh Start restarts the entry window and wins over sampling U.
          timer_d = '0;
        end else if (timer_q == CODE_LEN_C) begin
          // Only this edge samples U; earlier pulses are not remembered.
          timer_d = '0;
          if (U) begin
            state_d  = UNLOCKED;
            unlock_d = 1'b1;
            fail_d   = 2'd0;
          end else if (fail_inc == MAX_FAILS_W_C) begin
            // The count stops at MAX_FAILS; lockout exit is the only way
            // back down, so it can never wrap.
            state_d = LOCKOUT;
            alarm_d = 1'b1;
            fail_d  = MAX_FAILS_C;
          end else begin
            state_d = IDLE;
            fail_d  = fail_inc[1:0];
          end
        end else begin
          timer_d = timer_q + TIMER_ONE_C;
        end
      end

      UNLOCKED: begin
        if (timer_q == UNLOCK_LAST_C) begin
          state_d  = IDLE;
          timer_d  = '0;
          unlock_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_ONE_C;
        end
      end

      LOCKOUT: begin
        if (timer_q == LOCK_LAST_C) begin
          state_d = IDLE;
          timer_d = '0;
          alarm_d = 1'b0;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q + TIMER_ONE_C;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_controller.sv
// ---------------------------------------------------------------------------
// tb_lock_controller
//
// Purpose:
//   Self-checking bench for lock_controller. A reference model keeps the
//   lock's mode and the absolute edge number at which the current phase
//   ends (sample edge of an attempt, end of unlock, end of lockout).
//   Directed scenarios and a random run are checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_lock_controller;

  localparam int CODE_LEN       = 4;
  localparam int UNLOCK_CYCLES  = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int MAX_FAILS      = 3;
  localparam int CNT_W          = 8;

  logic       clk;
  logic       rst;
  logic       start_in;
  logic       u;
  logic       start_out;
  logic       unlock;
  logic       alarm;
  logic [1:0] fail_count;

  int vectors;
  int miscompares;

  lock_controller #(
    .CODE_LEN      (CODE_LEN),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .MAX_FAILS     (MAX_FAILS),
    .CNT_W         (CNT_W)
  ) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Start_In  (start_in),
    .U         (u),
    .Start_Out (start_out),
    .Unlock    (unlock),
    .Alarm     (alarm),
    .Fail_Count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------
  // Reference model: mode + absolute deadline edge.
  // ------------------------------------------------------------------
  localparam int M_IDLE    = 0;
  localparam int M_ATTEMPT = 1;
  localparam int M_OPEN    = 2;
  localparam int M_LOCKED  = 3;

  int         m_mode;
  int         m_due;
  int         edge_no;
  logic       m_unlock;
  logic       m_alarm;
  logic [1:0] m_fails;

  function automatic logic exp_start_out();
    return start_in && !rst && (m_mode == M_IDLE || m_mode == M_ATTEMPT);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_mode   = M_IDLE;
      m_unlock = 1'b0;
      m_alarm  = 1'b0;
      m_fails  = 2'd0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start_in) begin
            m_mode = M_ATTEMPT;
            m_due  = edge_no + CODE_LEN + 1;
          end
        end
        M_ATTEMPT: begin
          if (start_in) begin
            m_due = edge_no + CODE_LEN + 1;
          end else if (edge_no == m_due) begin
            if (u) begin
              m_mode   = M_OPEN;
              m_unlock = 1'b1;
              m_fails  = 2'd0;
              m_due    = edge_no + UNLOCK_CYCLES;
            end else if (int'(m_fails) + 1 >= MAX_FAILS) begin
              m_mode  = M_LOCKED;
              m_alarm = 1'b1;
              m_fails = 2'(MAX_FAILS);
              m_due   = edge_no + LOCKOUT_CYCLES;
            end else begin
              m_mode  = M_IDLE;
              m_fails = m_fails + 2'd1;
            end
          end
        end
        M_OPEN: begin
          if (edge_no == m_due) begin
            m_mode   = M_IDLE;
            m_unlock = 1'b0;
          end
        end
        default: begin
          if (edge_no == m_due) begin
            m_mode  = M_IDLE;
            m_alarm = 1'b0;
            m_fails = 2'd0;
          end
        end
      endcase
    end
  endtask

  // Apply inputs mid-cycle, then let combinational Start_Out settle.
  task automatic drive(input logic r, input logic s, input logic uu);
    @(negedge clk);
    rst      = r;
    start_in = s;
    u        = uu;
    #1;
  endtask

  // Rising edge, advance model, sample registered outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
  endtask

  task automatic go_idle();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    edge_no = 0;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1);
    vectors++;
    if (start_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_out got %b expected 0", start_out);
    end
    tick();
    vectors++;
    if ({unlock, alarm, fail_count} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs got U=%b A=%b F=%0d expected 0/0/0",
               unlock, alarm, fail_count);
    end
    $display("test_reset done");
  endtask

  // Start at edge 0, U at edge 5, a Start pulse while open.
  task automatic test_unlock();
    int open_cycles;
    open_cycles = 0;
    go_idle();
    for (int c = 0; c <= 16; c++) begin
      drive(1'b0, c == 0 || c == 8, c == 5);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL unlock_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL unlock_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
      if (unlock === 1'b1) open_cycles++;
    end
    vectors++;
    if (open_cycles != UNLOCK_CYCLES) begin
      miscompares++;
      $display("FAIL unlock_width got %0d expected %0d", open_cycles, UNLOCK_CYCLES);
    end
    $display("test_unlock done, unlock high %0d cycles", open_cycles);
  endtask

  // Three failing attempts; Start held high through the lockout.
  task automatic test_lockout();
    int alarm_cycles;
    alarm_cycles = 0;
    go_idle();
    for (int c = 0; c <= 36; c++) begin
      drive(1'b0, c == 0 || c == 6 || c == 12 || (c >= 18 && c <= 30), 1'b0);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL lockout_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL lockout_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
      if (alarm === 1'b1) alarm_cycles++;
    end
    vectors++;
    if (alarm_cycles != LOCKOUT_CYCLES || fail_count !== 2'd0) begin
      miscompares++;
      $display("FAIL lockout_width got %0d/F=%0d expected %0d/F=0",
               alarm_cycles, fail_count, LOCKOUT_CYCLES);
    end
    $display("test_lockout done, alarm high %0d cycles", alarm_cycles);
  endtask

  // Two failures then a success clears the count without an alarm.
  task automatic test_fail_then_success();
    int alarm_cycles;
    alarm_cycles = 0;
    go_idle();
    for (int c = 0; c <= 28; c++) begin
      drive(1'b0, c == 0 || c == 6 || c == 12, c == 17);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL fts_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL fts_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
      if (alarm === 1'b1) alarm_cycles++;
    end
    vectors++;
    if (alarm_cycles != 0) begin
      miscompares++;
      $display("FAIL fts_no_alarm got %0d alarm cycles expected 0", alarm_cycles);
    end
    $display("test_fail_then_success done");
  endtask

  // Restart at edge 2 moves the sample from edge 5 to edge 7.
  task automatic test_restart();
    go_idle();
    for (int c = 0; c <= 10; c++) begin
      drive(1'b0, c == 0 || c == 2, c == 5 || c == 7);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL restart_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL restart_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
    end
    $display("test_restart done");
  endtask

  // An early U pulse is not remembered at the sample edge.
  task automatic test_early_u();
    go_idle();
    for (int c = 0; c <= 7; c++) begin
      drive(1'b0, c == 0, c == 3);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL early_u_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL early_u_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
    end
    $display("test_early_u done");
  endtask

  // Reset in the middle of a lockout and of an unlock, then Start at once.
  task automatic test_reset_mid();
    go_idle();
    for (int c = 0; c <= 34; c++) begin
      drive(c == 22 || c == 31,
            c == 0 || c == 6 || c == 12 || c == 23 || c == 32,
            c == 28);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL reset_mid_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL reset_mid_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int unlocks;
    int lockouts;
    unlocks  = 0;
    lockouts = 0;
    go_idle();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1);
      vectors++;
      if (start_out !== exp_start_out()) begin
        miscompares++;
        $display("FAIL random_start_out c=%0d got %b expected %b", c, start_out, exp_start_out());
      end
      tick();
      vectors++;
      if ({unlock, alarm, fail_count} !== {m_unlock, m_alarm, m_fails}) begin
        miscompares++;
        $display("FAIL random_regs c=%0d got %b%b%0d expected %b%b%0d",
                 c, unlock, alarm, fail_count, m_unlock, m_alarm, m_fails);
      end
      if (m_mode == M_OPEN && m_due == edge_no + UNLOCK_CYCLES) unlocks++;
      if (m_mode == M_LOCKED && m_due == edge_no + LOCKOUT_CYCLES) lockouts++;
    end
    $display("test_random done, %0d unlocks, %0d lockouts", unlocks, lockouts);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_no     = 0;
    m_mode      = M_IDLE;
    m_due       = 0;
    m_unlock    = 1'b0;
    m_alarm     = 1'b0;
    m_fails     = 2'd0;
    rst         = 1'b1;
    start_in    = 1'b0;
    u           = 1'b0;

    test_reset();
    test_unlock();
    test_lockout();
    test_fail_then_success();
    test_restart();
    test_early_u();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
